maquina_estados: RTL and testbench
==================================

MAQUINA_ESTADOS -- requirements
Module: maquina_estados

Interface
REQ-001 SHALL have parameter N_FIFOS, default 8, number of FIFOs monitored (four input, four output).
REQ-002 SHALL have parameter UMBRAL_W, default 3, width of the threshold values.
REQ-003 SHALL have parameter ALTO_RST, default 3'd6, almost-full threshold applied after reset.
REQ-004 SHALL have parameter BAJO_RST, default 3'd1, almost-empty threshold applied after reset.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic on rising edge.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port init, input, 1 bit: request to enter or hold INIT and load thresholds.
REQ-008 SHALL have port alto_in, input, UMBRAL_W bits: almost-full threshold candidate.
REQ-009 SHALL have port bajo_in, input, UMBRAL_W bits: almost-empty threshold candidate.
REQ-010 SHALL have port empty_fifos, input, N_FIFOS bits: per-FIFO empty flags; 1 means empty.
REQ-011 SHALL have port error_full, input, N_FIFOS bits: per-FIFO flag for a push while full.
REQ-012 SHALL have port alto, output, UMBRAL_W bits: registered threshold driven to all FIFOs.
REQ-013 SHALL have port bajo, output, UMBRAL_W bits: registered threshold driven to all FIFOs.
REQ-014 SHALL have port state, output, 3 bits: current state code.
REQ-015 SHALL have ports idle_out, active_out and error_out, each output, 1 bit: state decodes; idle_out drives the counter's IDLE input.
REQ-016 SHALL have port error_src, output, N_FIFOS bits: sticky record of the FIFOs that overflowed.
REQ-017 SHALL have port cfg_err, output, 1 bit: invalid-threshold error flag.

Function
REQ-018 SHALL implement a Moore FSM with the state codes RESET=0, INIT=1, IDLE=2, ACTIVE=3 and ERROR=4.
REQ-019 SHALL update the state register only on a clk edge; idle_out, active_out, error_out and state SHALL decode only from the state register.
REQ-020 SHALL make every output change one cycle after the edge that samples its cause; there is no combinational input-to-output path.
REQ-021 SHALL move from RESET to INIT on the first edge with reset low.
REQ-022 SHALL, in INIT with init=1, load alto and bajo from alto_in and bajo_in on every edge.
REQ-023 SHALL, in INIT with init=0, go to IDLE.
REQ-024 SHALL, in IDLE, go to ACTIVE when any empty_fifos bit is 0, and otherwise stay in IDLE.
REQ-025 SHALL, in ACTIVE, go to IDLE when all empty_fifos bits are 1, and otherwise stay in ACTIVE.
REQ-026 SHALL, in IDLE or ACTIVE, go to INIT when init=1; alto and bajo are reloaded from the INIT cycle onward.
REQ-027 SHALL, in INIT, IDLE or ACTIVE, go to ERROR when any error_full bit is 1.
REQ-028 SHALL apply the transition priority: reset, then error_full, then init, then empty-based transitions.
REQ-029 SHALL OR error_full into error_src on the ERROR-entry edge and on every edge while in ERROR.
REQ-030 SHALL leave ERROR only on reset; init SHALL be ignored in ERROR.
REQ-031 SHALL keep alto and bajo unchanged in every state except INIT.

Reset
REQ-032 SHALL, on a reset edge from any state (including mid-INIT), set state to RESET and load alto=ALTO_RST and bajo=BAJO_RST.
REQ-033 SHALL, on a reset edge, clear error_src, cfg_err, idle_out, active_out and error_out to 0.

Configuration
REQ-034 SHALL, with UMBRAL_CHECK_EN defined, take the INIT-to-IDLE exit to ERROR with cfg_err=1 when the loaded bajo is greater than or equal to the loaded alto; alto and bajo SHALL keep the loaded values.
REQ-035 SHALL, without UMBRAL_CHECK_EN, perform no threshold check and tie cfg_err to 0.

Structure
REQ-036 SHALL place the state-code localparams and the ALTO_RST/BAJO_RST defaults in the shared package maquina_estados_pkg.
REQ-037 SHALL be a single module; no sub-module is natural at this size.

Verification
REQ-038 SHALL cover: reset for 2 cycles, then release -> state goes 0, then 1, then 2 (with init=0 and empty_fifos=8'hFF); alto=6, bajo=1.
REQ-039 SHALL cover: init=1 with alto_in=5 and bajo_in=2 for 1 cycle, then init=0 -> alto=5, bajo=2 from the next cycle; state returns to IDLE.
REQ-040 SHALL cover: in IDLE, empty_fifos=8'hFE -> active_out=1 next cycle; empty_fifos=8'hFF -> idle_out=1 next cycle.
REQ-041 SHALL cover: in ACTIVE, error_full=8'h10 followed by 8'h02 -> error_out=1 and error_src=8'h12; init=1 has no effect; reset -> state 0 and error_src=0.
REQ-042 SHALL cover: error_full=8'h01 and init=1 in the same cycle -> state goes to ERROR (error_full has priority).
REQ-043 SHALL cover: with UMBRAL_CHECK_EN, load alto_in=2 and bajo_in=3, then drop init -> state 4 and cfg_err=1; without the macro the same stimulus -> state 2 and cfg_err=0.

Source files
------------

// File: rtl/maquina_estados_pkg.sv
// Shared state codes and reset threshold defaults for the FIFO monitor FSM.
package maquina_estados_pkg;

  localparam logic [2:0] ST_RESET  = 3'd0;
  localparam logic [2:0] ST_INIT   = 3'd1;
  localparam logic [2:0] ST_IDLE   = 3'd2;
  localparam logic [2:0] ST_ACTIVE = 3'd3;
  localparam logic [2:0] ST_ERROR  = 3'd4;

  typedef enum logic [2:0] {
    E_RESET  = ST_RESET,
    E_INIT   = ST_INIT,
    E_IDLE   = ST_IDLE,
    E_ACTIVE = ST_ACTIVE,
    E_ERROR  = ST_ERROR
  } estado_t;

  localparam logic [2:0] ALTO_RST_DEF = 3'd6;
  localparam logic [2:0] BAJO_RST_DEF = 3'd1;

endpackage

// File: rtl/maquina_estados.sv
// FIFO-bank monitor: owns the almost-full/almost-empty thresholds and tracks overflow.
// Optional threshold sanity check on INIT exit enabled by macro UMBRAL_CHECK_EN.
//
// state  | meaning
// RESET  | held in reset, thresholds at defaults
// INIT   | thresholds loaded from alto_in/bajo_in while init=1
// IDLE   | all FIFOs empty
// ACTIVE | at least one FIFO holds data
// ERROR  | overflow (or bad thresholds) seen; only reset leaves
module maquina_estados
  import maquina_estados_pkg::*;
#(
  parameter int                     N_FIFOS  = 8,
  parameter int                     UMBRAL_W = 3,
  parameter logic [UMBRAL_W-1:0]    ALTO_RST = UMBRAL_W'(ALTO_RST_DEF),
  parameter logic [UMBRAL_W-1:0]    BAJO_RST = UMBRAL_W'(BAJO_RST_DEF)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                init,
  input  logic [UMBRAL_W-1:0] alto_in,
  input  logic [UMBRAL_W-1:0] bajo_in,
  input  logic [N_FIFOS-1:0]  empty_fifos,
  input  logic [N_FIFOS-1:0]  error_full,
  output logic [UMBRAL_W-1:0] alto,
  output logic [UMBRAL_W-1:0] bajo,
  output logic [2:0]          state,
  output logic                idle_out,
  output logic                active_out,
  output logic                error_out,
  output logic [N_FIFOS-1:0]  error_src,
  output logic                cfg_err
);

  estado_t state_q;

`ifdef UMBRAL_CHECK_EN
  logic cfg_err_q;
  assign cfg_err = cfg_err_q;
`else
  assign cfg_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= E_RESET;
      alto      <= ALTO_RST;
      bajo      <= BAJO_RST;
      error_src <= '0;
`ifdef UMBRAL_CHECK_EN
      cfg_err_q <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        E_RESET: state_q <= E_INIT;
        E_INIT: begin
          if (|error_full) begin
            state_q   <= E_ERROR;
            error_src <= error_src | error_full;
          end else if (init) begin
            alto <= alto_in;
            bajo <= bajo_in;
          end else begin
`ifdef UMBRAL_CHECK_EN
            if (bajo >= alto) begin
              state_q   <= E_ERROR;
              cfg_err_q <= 1'b1;
            end else begin
              state_q <= E_IDLE;
            end
`else
            state_q <= E_IDLE;
`endif
          end
        end
        E_IDLE, E_ACTIVE: begin
          if (|error_full) begin
            state_q   <= E_ERROR;
            error_src <= error_src | error_full;
          end else if (init) begin
            // Load on the entry edge so a one-cycle init pulse still takes effect.
            state_q <= E_INIT;
            alto    <= alto_in;
            bajo    <= bajo_in;
          end else if (state_q == E_IDLE && !(&empty_fifos)) begin
            state_q <= E_ACTIVE;
          end else if (state_q == E_ACTIVE && (&empty_fifos)) begin
            state_q <= E_IDLE;
          end
        end
        E_ERROR: error_src <= error_src | error_full;
        default: state_q <= E_RESET;
      endcase
    end
  end

  assign state      = state_q;
  assign idle_out   = (state_q == E_IDLE);
  assign active_out = (state_q == E_ACTIVE);
  assign error_out  = (state_q == E_ERROR);

endmodule

// File: tb/tb_maquina_estados.sv
// Directed bench for maquina_estados; expected values are hand-computed per step.
module tb_maquina_estados;

  logic       clk = 1'b0;
  logic       reset;
  logic       init;
  logic [2:0] alto_in;
  logic [2:0] bajo_in;
  logic [7:0] empty_fifos;
  logic [7:0] error_full;
  logic [2:0] alto;
  logic [2:0] bajo;
  logic [2:0] state;
  logic       idle_out;
  logic       active_out;
  logic       error_out;
  logic [7:0] error_src;
  logic       cfg_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  maquina_estados dut (
    .clk         (clk),
    .reset       (reset),
    .init        (init),
    .alto_in     (alto_in),
    .bajo_in     (bajo_in),
    .empty_fifos (empty_fifos),
    .error_full  (error_full),
    .alto        (alto),
    .bajo        (bajo),
    .state       (state),
    .idle_out    (idle_out),
    .active_out  (active_out),
    .error_out   (error_out),
    .error_src   (error_src),
    .cfg_err     (cfg_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic check_decodes(input string tag, input logic i, input logic a, input logic e);
    check({tag, "_idle"}, {31'd0, idle_out}, {31'd0, i});
    check({tag, "_active"}, {31'd0, active_out}, {31'd0, a});
    check({tag, "_error"}, {31'd0, error_out}, {31'd0, e});
  endtask

  initial begin
    reset = 1'b1; init = 1'b0; alto_in = 3'd0; bajo_in = 3'd0;
    empty_fifos = 8'hFF; error_full = 8'h00;

    // Reset for two cycles
    step(); step();
    check("rst_state", 32'(state), 32'd0);
    check("rst_alto", 32'(alto), 32'd6);
    check("rst_bajo", 32'(bajo), 32'd1);
    check("rst_src", 32'(error_src), 32'h00);
    check("rst_cfg", 32'(cfg_err), 32'd0);
    check_decodes("rst", 1'b0, 1'b0, 1'b0);

    reset = 1'b0;
    step(); check("rel_init", 32'(state), 32'd1);
    step(); check("rel_idle", 32'(state), 32'd2);
    check_decodes("idle0", 1'b1, 1'b0, 1'b0);
    check("rel_alto", 32'(alto), 32'd6);
    check("rel_bajo", 32'(bajo), 32'd1);

    // One-cycle init pulse loads thresholds
    init = 1'b1; alto_in = 3'd5; bajo_in = 3'd2;
    step(); check("ld_state", 32'(state), 32'd1);
    init = 1'b0;
    step(); check("ld_back_idle", 32'(state), 32'd2);
    check("ld_alto", 32'(alto), 32'd5);
    check("ld_bajo", 32'(bajo), 32'd2);

    // Thresholds hold outside INIT
    alto_in = 3'd7; bajo_in = 3'd0;
    step(); check("hold_alto", 32'(alto), 32'd5);
    check("hold_bajo", 32'(bajo), 32'd2);

    // Empty-driven IDLE/ACTIVE transitions
    empty_fifos = 8'hFE;
    step(); check("act_state", 32'(state), 32'd3);
    check_decodes("act", 1'b0, 1'b1, 1'b0);
    step(); check("act_stay", 32'(state), 32'd3);
    empty_fifos = 8'hFF;
    step(); check("idle_state", 32'(state), 32'd2);
    check_decodes("idle1", 1'b1, 1'b0, 1'b0);
    empty_fifos = 8'h7F;
    step(); check("act2_state", 32'(state), 32'd3);

    // Overflow accumulation in ERROR, init ignored
    error_full = 8'h10;
    step(); check("err_state", 32'(state), 32'd4);
    check("err_src1", 32'(error_src), 32'h10);
    check_decodes("err", 1'b0, 1'b0, 1'b1);
    error_full = 8'h02;
    step(); check("err_src2", 32'(error_src), 32'h12);
    error_full = 8'h00; init = 1'b1; alto_in = 3'd3;
    step(); check("err_init_state", 32'(state), 32'd4);
    check("err_init_alto", 32'(alto), 32'd5);
    check("err_src3", 32'(error_src), 32'h12);
    init = 1'b0; empty_fifos = 8'hFF;
    reset = 1'b1;
    step(); check("err_rst_state", 32'(state), 32'd0);
    check("err_rst_src", 32'(error_src), 32'h00);
    check("err_rst_alto", 32'(alto), 32'd6);
    check_decodes("err_rst", 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    step(); step(); check("re_idle", 32'(state), 32'd2);

    // error_full outranks init
    error_full = 8'h01; init = 1'b1; alto_in = 3'd4;
    step(); check("prio_state", 32'(state), 32'd4);
    check("prio_src", 32'(error_src), 32'h01);
    check("prio_alto", 32'(alto), 32'd6);
    error_full = 8'h00; init = 1'b0;
    reset = 1'b1; step(); reset = 1'b0;
    step(); step(); check("re_idle2", 32'(state), 32'd2);

    // Reset mid-INIT restores defaults
    init = 1'b1; alto_in = 3'd7; bajo_in = 3'd3;
    step(); check("mid_init", 32'(state), 32'd1);
    check("mid_alto", 32'(alto), 32'd7);
    reset = 1'b1;
    step(); check("mid_rst_state", 32'(state), 32'd0);
    check("mid_rst_alto", 32'(alto), 32'd6);
    check("mid_rst_bajo", 32'(bajo), 32'd1);
    reset = 1'b0; init = 1'b0;
    step(); step(); check("re_idle3", 32'(state), 32'd2);

    // Inverted thresholds
    init = 1'b1; alto_in = 3'd2; bajo_in = 3'd3;
    step(); check("cfg_ld_state", 32'(state), 32'd1);
    step(); check("cfg_ld_alto", 32'(alto), 32'd2);
    check("cfg_ld_bajo", 32'(bajo), 32'd3);
    init = 1'b0;
    step();
`ifdef UMBRAL_CHECK_EN
    check("cfg_state", 32'(state), 32'd4);
    check("cfg_flag", 32'(cfg_err), 32'd1);
`else
    check("cfg_state", 32'(state), 32'd2);
    check("cfg_flag", 32'(cfg_err), 32'd0);
`endif
    check("cfg_keep_alto", 32'(alto), 32'd2);
    check("cfg_keep_bajo", 32'(bajo), 32'd3);
    reset = 1'b1;
    step(); check("cfg_rst_flag", 32'(cfg_err), 32'd0);
    check("cfg_rst_state", 32'(state), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
